// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between two requesters
// Ports: clk, rst_n (async active-low); req0_*/req1_* valid/ready/a/b/op request channels;
// resp_valid/resp_ready/resp_result/resp_id response channel; alu_a/alu_b/alu_op/alu_result ALU link.
// Optional: define ALU_ARB_STATS_EN to add saturating 8-bit grant counters gnt_cnt0/gnt_cnt1.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int OPW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_id,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]       gnt_cnt0,
  output logic [7:0]       gnt_cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic ptr, id, gnt, gnt_id;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0] op_q;
  // ready is a same-cycle grant pulse; it depends only on state, ptr and the valids
  assign gnt = (state == IDLE) && (req0_valid || req1_valid);
  assign gnt_id = (req0_valid && req1_valid) ? ptr : req1_valid;
  assign req0_ready = gnt && !gnt_id;
  assign req1_ready = gnt && gnt_id;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      id <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      resp_valid <= 1'b0;
      resp_result <= '0;
      resp_id <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt) begin
          a_q <= gnt_id ? req1_a : req0_a;
          b_q <= gnt_id ? req1_b : req0_b;
          op_q <= gnt_id ? req1_op : req0_op;
          id <= gnt_id;
          ptr <= ~gnt_id;
          state <= EXEC;
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_id <= id;
          resp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && gnt_cnt0 != 8'hFF) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (req1_ready && gnt_cnt1 != 8'hFF) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`endif
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` (`a`, `b`, `op` -> `result`) between two requesters, e.g. the main datapath and a branch/address helper.
- Round-robin grant, registered operands and result, valid/ready handshake on both sides.
- Sits between the requesters and an externally instantiated `alu`. It only sequences; it never decodes `op`.

Parameters:
- WIDTH, 4, operand/result width; matches the `alu` data width.
- OPW, 4, ALU opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  one-cycle pulse: requester 0's operands were captured this cycle.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req0_op  in  OPW  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_result  out  WIDTH  registered ALU result.
- resp_id  out  1  requester that owns resp_result.
- alu_a  out  WIDTH  to `alu.a`.
- alu_b  out  WIDTH  to `alu.b`.
- alu_op  out  OPW  to `alu.op`.
- alu_result  in  WIDTH  from `alu.result`.

Behaviour:
- Reset: clk and rst_n as above; reset is asynchronous and active-low. On reset, all outputs are 0, state=IDLE, priority pointer ptr=0, operand regs=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid: grant. If both are valid, grant requester ptr.
  - Assert the winner's reqN_ready for exactly this cycle and capture its a/b/op into the operand regs.
  - Latch the grant id; set ptr = ~id; go to EXEC.
  - If no request is valid: stay in IDLE.
- Ready rules:
  - The loser's ready stays 0.
  - ready is never asserted outside IDLE.
  - ready does not depend combinationally on resp_ready.
- EXEC:
  - alu_a/alu_b/alu_op are driven from the operand regs (they are driven from the regs in every state).
  - At the clock edge, alu_result is registered into resp_result and id into resp_id.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_result and resp_id are held stable.
  - When resp_ready=1: resp_valid goes to 0 next cycle, go to IDLE.
  - A new grant is possible at the earliest in the IDLE cycle that follows.
- Timing:
  - Latency: grant at cycle T, resp_valid at T+2.
  - Max throughput: one operation per 3 cycles with resp_ready tied high.
- Requests: requesters must hold valid/a/b/op until they see ready. Deasserting valid before grant withdraws the request without error.
- Arithmetic: the block passes the op through and does no arithmetic. Overflow and wrap are the ALU's behaviour, truncated to WIDTH.
- Reset mid-operation: asserting rst_n=0 in any state immediately clears resp_valid and state, and sets ptr=0. The in-flight operation is lost and no ready is reissued.
- Simultaneous events: a requester that becomes valid in the same cycle the arbiter returns to IDLE is eligible for the following IDLE evaluation. Arbitration is evaluated only in IDLE.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1 (8 bits each).
  - Each counts grants to its requester, saturating at 255.
  - Reset to 0 by rst_n.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, no requests -> all outputs 0 and ready never pulses over 10 cycles.
- Bench instantiates the codebase `alu` (0000 AND, 0001 OR, 0010 ADD, 0110 SUB). req0 a=6 b=2 op=0010 at T -> req0_ready=1 at T, resp_valid=1 at T+2 with resp_result=8, resp_id=0.
- Both valid after reset, req0 AND(6,2), req1 OR(6,2), resp_ready=1:
  - first response result=2, id=0;
  - second response result=6, id=1;
  - a third simultaneous pair is then granted to req0 again (round-robin alternation).
- resp_ready=0 for 5 cycles in RESP -> resp_result/resp_id stable, no reqN_ready pulses. Releasing resp_ready -> resp_valid drops next cycle.
- req1 a=2 b=6 op=0110 -> resp_result=4'hC (wrap passed through), resp_id=1.
- rst_n pulsed low during EXEC -> resp_valid stays 0. Next simultaneous request pair is granted to req0. With ALU_ARB_STATS_EN, counters read 0.
